// File: rtl/shift_register_cache_feeder.sv
// shift_register_cache_feeder
// Producer side of the RAM-based convolution shift-register cache. Accepts an
// upstream two-feature beat stream and writes each frame into the cache one
// write per beat in raster order, optionally wrapped in the one-pixel zero
// border needed by a 3x3 stride-1 pad-1 convolution.
// Build option: define FEEDER_PADDING_EN to emit the zero border; without it
// the frame is data writes only and shift_size equals the row width.
`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif

module shift_register_cache_feeder #(
  parameter int unsigned FEATURE_WIDTH = `FEATURE_WIDTH
) (
  input  logic                       system_clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [9:0]                 cfg_row_size,
  input  logic [9:0]                 cfg_col_size,
  input  logic                       in_valid,
  input  logic [2*FEATURE_WIDTH-1:0] in_data,
  output logic                       in_ready,
  output logic                       wr_en,
  output logic [2*FEATURE_WIDTH-1:0] wr_data,
  output logic [9:0]                 shift_size,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       cfg_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] TOP    = 3'd1;
  localparam logic [2:0] LEFT   = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] RIGHT  = 3'd4;
  localparam logic [2:0] BOTTOM = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  logic [2:0] state_q;
  logic [9:0] r_q;
  logic [9:0] c_q;
  logic [9:0] x_q;
  logic [9:0] y_q;

  logic       cfg_ok;
  logic [9:0] r_last;
  logic [9:0] r_pad_last;
  logic [9:0] c_last;

  // Config legality and last-index compares derived from the latched frame size
  always_comb begin
    cfg_ok     = (cfg_row_size != '0) && (cfg_col_size != '0);
    r_last     = r_q - 10'd1;
    r_pad_last = r_q + 10'd1;
    c_last     = c_q - 10'd1;
  end

  // Handshake and status decoded from the state register only
  always_comb begin
    in_ready = (state_q == DATA);
    busy     = (state_q != IDLE);
  end

  // Frame sequencer with registered write port and status pulses.
  // The pad states are coded in both builds; without FEEDER_PADDING_EN no
  // transition leads into them, so they are unreachable.
  always_ff @(posedge system_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      r_q        <= '0;
      c_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      shift_size <= '0;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              r_q <= cfg_row_size;
              c_q <= cfg_col_size;
              x_q <= '0;
              y_q <= '0;
`ifdef FEEDER_PADDING_EN
              shift_size <= cfg_row_size + 10'd2;
              state_q    <= TOP;
`else
              shift_size <= cfg_row_size;
              state_q    <= DATA;
`endif
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        TOP: begin
          wr_en   <= 1'b1;
          wr_data <= '0;
          if (x_q == r_pad_last) begin
            x_q     <= '0;
            state_q <= LEFT;
          end else begin
            x_q <= x_q + 10'd1;
          end
        end
        LEFT: begin
          wr_en   <= 1'b1;
          wr_data <= '0;
          x_q     <= '0;
          state_q <= DATA;
        end
        DATA: begin
          if (in_valid) begin
            wr_en   <= 1'b1;
            wr_data <= in_data;
            if (x_q == r_last) begin
              x_q <= '0;
`ifdef FEEDER_PADDING_EN
              state_q <= RIGHT;
`else
              if (y_q == c_last) begin
                state_q <= DONE;
              end else begin
                y_q <= y_q + 10'd1;
              end
`endif
            end else begin
              x_q <= x_q + 10'd1;
            end
          end
        end
        RIGHT: begin
          wr_en   <= 1'b1;
          wr_data <= '0;
          x_q     <= '0;
          if (y_q == c_last) begin
            state_q <= BOTTOM;
          end else begin
            y_q     <= y_q + 10'd1;
            state_q <= LEFT;
          end
        end
        BOTTOM: begin
          wr_en   <= 1'b1;
          wr_data <= '0;
          if (x_q == r_pad_last) begin
            x_q     <= '0;
            state_q <= DONE;
          end else begin
            x_q <= x_q + 10'd1;
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_register_cache_feeder.md
# shift_register_cache_feeder

Producer side of the RAM-based convolution shift-register cache. Takes an upstream feature stream (two features per beat, valid/ready), adds the zero border a 3x3 stride-1 pad-1 convolution needs, and drives the cache's `wr_en`/`wr_data`/`shift_size` inputs. It presents each padded frame one write per beat, raster order. It sits between the feature input buffer and the cache chain in the conv component.

## Interface
- `FEATURE_WIDTH`, default `` `FEATURE_WIDTH ``: bits per feature; one beat carries two features.
- `system_clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; latches `cfg_row_size`/`cfg_col_size`, begins a frame. Ignored while `busy`.
- `cfg_row_size`  in  10  unpadded row width in beats; legal range 1..1021.
- `cfg_col_size`  in  10  unpadded row count; legal range 1..1023.
- `in_valid`  in  1  upstream beat valid.
- `in_data`  in  2*FEATURE_WIDTH  upstream beat.
- `in_ready`  out  1  feeder accepts `in_data` this cycle.
- `wr_en`  out  1  write strobe to cache.
- `wr_data`  out  2*FEATURE_WIDTH  write data to cache.
- `shift_size`  out  10  padded row width, held stable for the whole frame.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse after the last write of a frame.
- `cfg_err`  out  1  one-cycle pulse when `start` has `cfg_row_size==0` or `cfg_col_size==0`; the frame is not started.

## Operation
- FSM states: IDLE, TOP, LEFT, DATA, RIGHT, BOTTOM, DONE.
- On `start` with a legal config in IDLE:
  - latch `R = cfg_row_size` and `C = cfg_col_size`;
  - set `shift_size = R+2`;
  - clear the column counter `x` and row counter `y`;
  - go to TOP.
- TOP: emit `R+2` zero writes, one per cycle, then go to LEFT.
- LEFT: emit 1 zero write, then go to DATA.
- DATA:
  - `in_ready = 1`; each cycle with `in_valid & in_ready` produces a write of `in_data`;
  - when `in_valid` is low, write nothing (`wr_en=0`), which is a legal gap for the cache;
  - after `R` accepted beats, go to RIGHT.
- RIGHT: emit 1 zero write. If `y==C-1`, go to BOTTOM; else increment `y` and go to LEFT.
- BOTTOM: emit `R+2` zero writes, then go to DONE.
- DONE: one cycle; pulse `frame_done` and return to IDLE.
- Total writes per frame: `(R+2)*(C+2)`.
- Zero writes never stall, since the cache has no backpressure.
- `in_ready` is 0 in every state except DATA.
- `x` is 10 bits and compares against `R+1` or `R-1` as the state requires. `R+2 ≤ 1023` always fits in 10 bits, so there is no wrap.
- `start` while `busy` has no effect, and the latched config is unchanged.
- `rst` in any state returns to IDLE on the next edge and abandons the frame. No `frame_done` is issued for an abandoned frame.

## Timing
- Reset values: `wr_en=0`, `wr_data=0`, `shift_size=0`, `busy=0`, `frame_done=0`, `cfg_err=0`, `in_ready=0`.
- `wr_en`/`wr_data` are registered. A write decided in cycle t (a pad cycle, or an accepted beat) appears at the outputs in cycle t+1.
- `in_ready` is decoded from the state register only, with no combinational path from `in_valid`.
- `busy` rises the cycle after `start` and falls in the cycle `frame_done` is high.
- The first `wr_en` appears 2 cycles after the `start` cycle (TOP entry plus output register).
- `frame_done` is asserted exactly one cycle after the final `wr_en`.
- `shift_size` updates the cycle after `start` and holds until the next accepted `start`.
- `cfg_err` asserts the cycle after the illegal `start`; `busy` stays 0.
- With `in_valid` tied high, a frame takes exactly `(R+2)*(C+2)+1` cycles from `busy` rise to `frame_done`.

## Configuration
- `FEEDER_PADDING_EN` defined: behaviour as above.
- `FEEDER_PADDING_EN` undefined:
  - TOP, LEFT, RIGHT and BOTTOM are never entered; the frame is `R*C` data writes only;
  - `shift_size = R`;
  - legal `cfg_row_size` range becomes 1..1023;
  - all other timing rules are unchanged.

## Test plan
- Full frame, no stalls: `R=4`, `C=3`, `in_valid=1`, beats 1..12 → `shift_size=6`; 30 writes in order 6 zeros, then rows of [0,a,b,c,d,0] ×3, then 6 zeros; `frame_done` one cycle after the 30th write.
- Upstream gaps: same config, `in_valid` toggling 1,0 → `wr_en` has gaps only in DATA rows; write count and order are unchanged; pad writes are contiguous.
- Illegal config: `start` with `R=0`, `C=5` → `cfg_err` pulse; `busy=0`; no writes; `shift_size` unchanged.
- Start while busy: second `start` with `R=8` mid-frame → ignored; `shift_size` stays 6; exactly 30 writes.
- Reset mid-frame: assert `rst` during the second data row → next cycle all outputs are at reset values; no `frame_done`; a following legal `start` produces a complete correct frame.
- Max width: `R=1021`, `C=1` → `shift_size=1023`; 3069 writes with no counter wrap; `frame_done` asserted once. Rerun with `FEEDER_PADDING_EN` undefined and `R=1023` → `shift_size=1023`, 1023 writes.
